affine_vga: RTL



---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_timing.sv | 73 +++++++
 rtl/affine_vga.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and helpers for the raster/affine video blocks: coefficient set,
// mode-total derivation and source pixel unpacking.
package vga_pkg;

  typedef struct packed {
    logic signed [15:0] ax;
    logic signed [15:0] ay;
    logic signed [15:0] bx;
    logic signed [15:0] by;
    logic signed [31:0] x0;
    logic signed [31:0] y0;
    logic               wrap;
    logic               fmt;
    logic [15:0]        border;
  } coef_t;

  // Unit-scale, unrotated mapping with wrap addressing and RGB565 source.
  function automatic coef_t identity_coef(input int frac);
    coef_t c;
    c      = '0;
    c.ax   = 16'(1 << frac);
    c.by   = 16'(1 << frac);
    c.wrap = 1'b1;
    return c;
  endfunction

  function automatic int line_total(input int vis, input int front, input int sync, input int back);
    return vis + front + sync + back;
  endfunction

  // Returns {r[4:0], g[5:0], b[4:0]} with every channel left-justified.
  function automatic logic [15:0] unpack_rgb(input logic [15:0] dq, input logic fmt);
    if (fmt) return {dq[11:8], 1'b0, dq[7:4], 2'b00, dq[3:0], 1'b0};
    return dq;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters (front, sync, back, visible order) with stage-0 strobes and
// hs/vs/de/frame_start delayed two cycles to line up with a two-stage pixel pipe.
module vga_timing
  import vga_pkg::*;
#(
  parameter int HVIS   = 1280,
  parameter int HFRONT = 48,
  parameter int HSYNC  = 112,
  parameter int HBACK  = 248,
  parameter int VVIS   = 1024,
  parameter int VFRONT = 1,
  parameter int VSYNC  = 3,
  parameter int VBACK  = 38
) (
  input  logic clk,
  input  logic rst,
  output logic vis,
  output logic line_start,
  output logic frame_end,
  output logic hs,
  output logic vs,
  output logic de,
  output logic frame_start
);

  localparam int HTOTAL = line_total(HVIS, HFRONT, HSYNC, HBACK);
  localparam int VTOTAL = line_total(VVIS, VFRONT, VSYNC, VBACK);
  localparam int HBLANK = HFRONT + HSYNC + HBACK;
  localparam int VBLANK = VFRONT + VSYNC + VBACK;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          hs0, vs0, fs0, v_vis;
  logic [3:0]    d1, d2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == HW'(HTOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VW'(VTOTAL - 1)) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_comb begin
    v_vis      = (vcnt >= VW'(VBLANK));
    vis        = (hcnt >= HW'(HBLANK)) && v_vis;
    line_start = (hcnt == HW'(HBLANK)) && v_vis;
    frame_end  = (hcnt == HW'(HTOTAL - 1)) && (vcnt == VW'(VTOTAL - 1));
    hs0        = !((hcnt >= HW'(HFRONT)) && (hcnt < HW'(HFRONT + HSYNC)));
    vs0        = !((vcnt >= VW'(VFRONT)) && (vcnt < VW'(VFRONT + VSYNC)));
    fs0        = (hcnt == '0) && (vcnt == '0);
  end

  // Delay line packs {hs, vs, de, frame_start}; idle value has syncs high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= 4'b1100;
      d2 <= 4'b1100;
    end else begin
      d1 <= {hs0, vs0, vis, fs0};
      d2 <= d1;
    end
  end

  assign {hs, vs, de, frame_start} = d2;

endmodule

// File: rtl/affine_vga.sv
// Raster generator fetching each pixel from async SRAM through an affine
// (matrix + origin) texture mapping; coefficients switch only at frame end.
module affine_vga
  import vga_pkg::*;
#(
  parameter int HVIS   = 1280,
  parameter int HFRONT = 48,
  parameter int HSYNC  = 112,
  parameter int HBACK  = 248,
  parameter int VVIS   = 1024,
  parameter int VFRONT = 1,
  parameter int VSYNC  = 3,
  parameter int VBACK  = 38,
  parameter int BM_XW  = 9,
  parameter int BM_YW  = 9,
  parameter int FRAC   = 7,
  parameter int RGB_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [15:0]          cfg_ax,
  input  logic signed [15:0]          cfg_ay,
  input  logic signed [15:0]          cfg_bx,
  input  logic signed [15:0]          cfg_by,
  input  logic signed [BM_XW+FRAC:0]  cfg_x0,
  input  logic signed [BM_YW+FRAC:0]  cfg_y0,
  input  logic                        cfg_wrap,
  input  logic [15:0]                 cfg_border,
  input  logic                        cfg_fmt,
  input  logic                        cfg_load,
  output logic                        cfg_pending,
  output logic                        frame_start,
  output logic                        hs,
  output logic                        vs,
  output logic                        de,
  output logic [RGB_W-1:0]            r,
  output logic [RGB_W-1:0]            g,
  output logic [RGB_W-1:0]            b,
  output logic [BM_YW+BM_XW-1:0]      sram_addr,
  input  logic [15:0]                 sram_dq,
  output logic                        sram_ce_n,
  output logic                        sram_oe_n,
  output logic                        sram_we_n,
  output logic                        sram_lb_n,
  output logic                        sram_ub_n
);

  localparam int    UW       = BM_XW + FRAC + 2;
  localparam int    VWD      = BM_YW + FRAC + 2;
  localparam coef_t COEF_RST = identity_coef(FRAC);

  logic vis, line_start, frame_end;

  vga_timing #(
    .HVIS(HVIS), .HFRONT(HFRONT), .HSYNC(HSYNC), .HBACK(HBACK),
    .VVIS(VVIS), .VFRONT(VFRONT), .VSYNC(VSYNC), .VBACK(VBACK)
  ) u_timing (
    .clk(clk), .rst(rst), .vis(vis), .line_start(line_start), .frame_end(frame_end),
    .hs(hs), .vs(vs), .de(de), .frame_start(frame_start)
  );

  // Config handshake: a cfg_load pulse captures every cfg_* input into the pending
  // set and raises cfg_pending; the frame-end cycle promotes pending to active and
  // drops cfg_pending unless a new load lands on that same cycle.
  coef_t cfg_in, act, pend, next_set;

  always_comb begin
    cfg_in        = '0;
    cfg_in.ax     = cfg_ax;
    cfg_in.ay     = cfg_ay;
    cfg_in.bx     = cfg_bx;
    cfg_in.by     = cfg_by;
    cfg_in.x0     = 32'(cfg_x0);
    cfg_in.y0     = 32'(cfg_y0);
    cfg_in.wrap   = cfg_wrap;
    cfg_in.fmt    = cfg_fmt;
    cfg_in.border = cfg_border;
    next_set      = cfg_pending ? pend : act;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act         <= COEF_RST;
      pend        <= COEF_RST;
      cfg_pending <= 1'b0;
    end else begin
      if (frame_end && cfg_pending) act <= pend;
      if (cfg_load) pend <= cfg_in;
      cfg_pending <= cfg_load | (cfg_pending & ~frame_end);
    end
  end

  logic signed [UW-1:0]  u_acc, u_line, u_pix;
  logic signed [VWD-1:0] v_acc, v_line, v_pix;
  logic                  u_ok, v_ok, in_rng;

  // On the line-start cycle the line origin is used directly so the first pixel
  // enters stage 1 without an extra cycle.
  always_comb begin
    u_pix  = line_start ? u_line : u_acc;
    v_pix  = line_start ? v_line : v_acc;
    u_ok   = (u_pix[UW-1 -: 2] == 2'b00);
    v_ok   = (v_pix[VWD-1 -: 2] == 2'b00);
    in_rng = act.wrap | (u_ok & v_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_line <= '0;
      v_line <= '0;
      u_acc  <= '0;
      v_acc  <= '0;
    end else begin
      if (frame_end) begin
        u_line <= UW'(next_set.x0);
        v_line <= VWD'(next_set.y0);
      end else if (line_start) begin
        u_line <= u_line + UW'($signed(act.bx));
        v_line <= v_line + VWD'($signed(act.by));
      end
      if (vis) begin
        u_acc <= u_pix + UW'($signed(act.ax));
        v_acc <= v_pix + VWD'($signed(act.ay));
      end
    end
  end

  // Stage 1: SRAM address/strobes plus the per-pixel attributes stage 2 needs,
  // carried along because the active set can switch under the last pixel.
  logic        vis1, bord1, fmt1;
  logic [15:0] bcol1, pix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      vis1      <= 1'b0;
      bord1     <= 1'b0;
      fmt1      <= 1'b0;
      bcol1     <= '0;
    end else begin
      if (vis) sram_addr <= {v_pix[FRAC +: BM_YW], u_pix[FRAC +: BM_XW]};
      sram_ce_n <= ~(vis & in_rng);
      vis1      <= vis;
      bord1     <= vis & ~in_rng;
      fmt1      <= act.fmt;
      bcol1     <= act.border;
    end
  end

  assign sram_oe_n = sram_ce_n;
  assign sram_lb_n = sram_ce_n;
  assign sram_ub_n = sram_ce_n;
  assign sram_we_n = 1'b1;

  always_comb pix = bord1 ? bcol1 : unpack_rgb(sram_dq, fmt1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else if (vis1) begin
      r <= RGB_W'(pix[15:11] >> (5 - RGB_W));
      g <= RGB_W'(pix[10:5] >> (6 - RGB_W));
      b <= RGB_W'(pix[4:0] >> (5 - RGB_W));
    end else begin
      r <= '0;
      g <= '0;
      b <= '0;
    end
  end

endmodule
